vector_register_bank: RTL and testbench



---
 rtl/vrb_pkg.sv | 50 +++++
 rtl/vrb_init_seq.sv | 63 ++++++
 rtl/vector_register_bank.sv | 96 +++++++++
 tb/tb_vector_register_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vrb_pkg.sv
// Shared types and helpers for the vector register bank.
// Helpers work on a maximal word/mask width so one definition serves every
// instantiation; callers cast their operands in and the result back out.
package vrb_pkg;

  localparam int unsigned VRB_MAX_W     = 256;
  localparam int unsigned VRB_MAX_LANES = 32;

  typedef logic [VRB_MAX_W-1:0]     vrb_word_t;
  typedef logic [VRB_MAX_LANES-1:0] vrb_mask_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } vrb_state_e;

  // Contents loaded into entry idx by the init sequencer.
  function automatic logic [31:0] init_value(input int unsigned idx,
                                             input int unsigned depth,
                                             input logic [31:0]  first_val,
                                             input logic [31:0]  last_val);
    logic [31:0] v;
    v = 32'h0;
    if (idx == 0)
      v = first_val;
    else if (idx == depth - 1)
      v = last_val;
    return v;
  endfunction

  // Lanes whose mask bit is set take new_word, the rest keep old_word.
  function automatic vrb_word_t lane_merge(input vrb_word_t   old_word,
                                           input vrb_word_t   new_word,
                                           input vrb_mask_t   mask,
                                           input int unsigned lane_bits);
    vrb_word_t lane_ones;
    vrb_word_t bit_mask;
    vrb_mask_t m;
    lane_ones = (VRB_MAX_W'(1) << lane_bits) - VRB_MAX_W'(1);
    bit_mask  = '0;
    m         = mask;
    for (int unsigned l = 0; l < VRB_MAX_LANES; l++) begin
      if (m[0])
        bit_mask = bit_mask | (lane_ones << (l * lane_bits));
      m = m >> 1;
    end
    return (new_word & bit_mask) | (old_word & ~bit_mask);
  endfunction

endpackage

// File: rtl/vrb_init_seq.sv
// Init sequencer: walks CNT over every entry after reset or a clear request.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   CLR            restart request, honoured only when READY
//   BUSY           high while the sequence runs
//   INIT_WE        entry INIT_ADDR is to be loaded this cycle
//   INIT_ADDR      entry being loaded
module vrb_init_seq
  import vrb_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned ABITS = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  output logic             BUSY,
  output logic             INIT_WE,
  output logic [ABITS-1:0] INIT_ADDR
);

  vrb_state_e       state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;

  // State register; reset restarts the walk from entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; CNT wraps to 0 naturally on the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ABITS'(1);
        if (cnt_q == ABITS'(DEPTH - 1))
          state_d = READY;
      end
      READY: begin
        if (CLR) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign BUSY      = (state_q == INIT);
  assign INIT_WE   = (state_q == INIT);
  assign INIT_ADDR = cnt_q;

endmodule

// File: rtl/vector_register_bank.sv
// Lane-masked vector register bank with two combinational read ports,
// scalar broadcast writes, optional write-to-read bypass and hardware init.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   CLR               re-run the init sequence (READY only)
//   WE3, WM, SCALAR   write enable, per-lane mask, lane-0 broadcast
//   A1, A2, A3        read addresses, write address
//   WD3               write data
//   RD1, RD2          read data, zero while BUSY
//   BUSY              init sequence in progress
module vector_register_bank
  import vrb_pkg::*;
#(
  parameter  int unsigned LANES      = 4,
  parameter  int unsigned LANE_BITS  = 8,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ABITS      = $clog2(DEPTH),
  localparam int unsigned W          = LANES * LANE_BITS,
  parameter  logic [31:0] INIT_FIRST = 32'd65536,
  parameter  logic [31:0] INIT_LAST  = 32'd81928,
  parameter  bit          BYPASS     = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             WE3,
  input  logic [LANES-1:0] WM,
  input  logic             SCALAR,
  input  logic [ABITS-1:0] A1,
  input  logic [ABITS-1:0] A2,
  input  logic [ABITS-1:0] A3,
  input  logic [W-1:0]     WD3,
  output logic [W-1:0]     RD1,
  output logic [W-1:0]     RD2,
  output logic             BUSY
);

  logic [W-1:0]     regs [DEPTH];
  logic             init_we;
  logic [ABITS-1:0] init_addr;
  logic [W-1:0]     init_word;
  logic [W-1:0]     wr_val;
  logic [W-1:0]     merged_a3;
  logic             init_wr;
  logic             user_wr;
  logic             fwd_ok;

  vrb_init_seq #(
    .DEPTH (DEPTH)
  ) u_init_seq (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .BUSY      (BUSY),
    .INIT_WE   (init_we),
    .INIT_ADDR (init_addr)
  );

  assign init_word = W'(init_value(32'(init_addr), DEPTH, INIT_FIRST, INIT_LAST));

  // Scalar mode replicates lane 0 across the word; the mask picks lanes.
  assign wr_val    = SCALAR ? {LANES{WD3[LANE_BITS-1:0]}} : WD3;
  assign merged_a3 = W'(lane_merge(VRB_MAX_W'(regs[A3]), VRB_MAX_W'(wr_val),
                                   VRB_MAX_LANES'(WM), LANE_BITS));

  // Reset blocks every array write on its edge; CLR drops a READY write.
  assign init_wr = init_we & ~RST;
  assign user_wr = ~RST & ~BUSY & WE3 & ~CLR;

  always_ff @(posedge CLK) begin
    if (init_wr)
      regs[init_addr] <= init_word;
    else if (user_wr)
      regs[A3] <= merged_a3;
  end

  // A write that will commit this edge may be forwarded to the read ports.
  assign fwd_ok = BYPASS & ~BUSY & WE3 & ~CLR;

  // Read ports with bypass and busy gating.
  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (fwd_ok && (A1 == A3))
      RD1 = W'(lane_merge(VRB_MAX_W'(regs[A1]), VRB_MAX_W'(wr_val),
                          VRB_MAX_LANES'(WM), LANE_BITS));
    if (fwd_ok && (A2 == A3))
      RD2 = W'(lane_merge(VRB_MAX_W'(regs[A2]), VRB_MAX_W'(wr_val),
                          VRB_MAX_LANES'(WM), LANE_BITS));
    if (BUSY) begin
      RD1 = '0;
      RD2 = '0;
    end
  end

endmodule

// File: tb/tb_vector_register_bank.sv
// Bench for vector_register_bank: a bypassing and a non-bypassing instance
// share one stimulus stream and are compared against a behavioural model.
module tb_vector_register_bank;

  logic        CLK;
  logic        rst, clr, we, scalar;
  logic [3:0]  wm, a1, a2, a3;
  logic [31:0] wd;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy_b, busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: register contents plus edges left in the init walk.
  logic [31:0] mem [16];
  int          init_left = 0;
  bit          checks_on = 1'b0;

  vector_register_bank #(.BYPASS(1'b1)) dut_b (
    .CLK(CLK), .RST(rst), .CLR(clr), .WE3(we), .WM(wm), .SCALAR(scalar),
    .A1(a1), .A2(a2), .A3(a3), .WD3(wd), .RD1(rd1_b), .RD2(rd2_b), .BUSY(busy_b)
  );

  vector_register_bank #(.BYPASS(1'b0)) dut_n (
    .CLK(CLK), .RST(rst), .CLR(clr), .WE3(we), .WM(wm), .SCALAR(scalar),
    .A1(a1), .A2(a2), .A3(a3), .WD3(wd), .RD1(rd1_n), .RD2(rd2_n), .BUSY(busy_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value the current write would leave in a word.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w);
    logic [31:0] v;
    logic [7:0]  b;
    v = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wm[i]) begin
        b = scalar ? wd[7:0] : wd[i*8 +: 8];
        v[i*8 +: 8] = b;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr, input bit byp);
    logic [31:0] v;
    if (init_left > 0) return 32'h0;
    v = mem[addr];
    if (byp && we && !clr && addr == a3) v = merge_word(v);
    return v;
  endfunction

  function automatic logic [31:0] init_val(input int idx);
    if (idx == 0)  return 32'd65536;
    if (idx == 15) return 32'd81928;
    return 32'h0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      init_left = 16;
      checks_on = 1'b1;
    end else if (init_left > 0) begin
      mem[16 - init_left] = init_val(16 - init_left);
      init_left--;
    end else if (clr) begin
      init_left = 16;
    end else if (we) begin
      mem[a3] = merge_word(mem[a3]);
    end
  endtask

  task automatic apply(input logic r, input logic c, input logic w, input logic [3:0] m,
                       input logic s, input logic [3:0] x1, input logic [3:0] x2,
                       input logic [3:0] x3, input logic [31:0] d);
    rst = r; clr = c; we = w; wm = m; scalar = s;
    a1 = x1; a2 = x2; a3 = x3; wd = d;
    #1;
    if (checks_on) begin
      check("busy_b", 32'(busy_b), 32'(init_left > 0));
      check("busy_n", 32'(busy_n), 32'(init_left > 0));
      check("rd1_b", rd1_b, model_read(a1, 1'b1));
      check("rd2_b", rd2_b, model_read(a2, 1'b1));
      check("rd1_n", rd1_n, model_read(a1, 1'b0));
      check("rd2_n", rd2_n, model_read(a2, 1'b0));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'($urandom), 4'($urandom), 4'h0, 32'h0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; wm = 4'h0; scalar = 1'b0;
    a1 = 4'h0; a2 = 4'h0; a3 = 4'h0; wd = 32'h0;
    @(negedge CLK);

    // Reset, then the init walk with writes attempted throughout.
    apply(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 4'h3, 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'($urandom), 4'($urandom),
            4'($urandom), $urandom);
      check("busy_during_init", 32'(busy_b), 32'h1);
      tick();
    end

    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h0);
    check("busy_after_init", 32'(busy_b), 32'h0);
    check("entry0", rd1_b, 32'h00010000);
    check("entry15", rd2_b, 32'h00014008);
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd7, 4'd3, 4'd0, 32'h0);
    check("entry7", rd1_b, 32'h0);
    check("entry3_clean", rd2_b, 32'h0);
    tick();

    // Masked write with bypass.
    apply(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 4'd3, 4'd3, 4'd3, 32'hAABBCCDD);
    check("bypass_masked", rd1_b, 32'h00BB00DD);
    check("nobypass_old", rd1_n, 32'h0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd3, 4'd3, 4'd0, 32'h0);
    check("masked_stored_b", rd1_b, 32'h00BB00DD);
    check("masked_stored_n", rd2_n, 32'h00BB00DD);
    tick();

    // Scalar broadcast.
    apply(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'd0, 4'd0, 4'd5, 32'h000000EE);
    tick();
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd5, 4'd5, 4'd0, 32'h0);
    check("scalar_bcast", rd1_b, 32'hEEEEEEEE);
    tick();

    // No-bypass write to A1==A3: old value, then new value after the edge.
    apply(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'd4, 4'd4, 4'd4, 32'h12345678);
    check("nb_before_edge", rd1_n, 32'h0);
    tick();
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd4, 4'd4, 4'd0, 32'h0);
    check("nb_after_edge", rd1_n, 32'h12345678);
    tick();

    // Zero mask writes nothing.
    apply(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'd4, 4'd4, 4'd4, 32'hFFFFFFFF);
    tick();

    // CLR with a coincident write: write dropped, full re-init.
    apply(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 4'd2, 4'd2, 4'd2, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'd3, 4'd5, 4'd5, 32'h55555555);
      check("busy_clr", 32'(busy_b), 32'h1);
      tick();
    end
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd3, 4'd5, 4'd0, 32'h0);
    check("clr_entry3", rd1_b, 32'h0);
    check("clr_entry5", rd2_b, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd2, 4'd0, 4'd0, 32'h0);
    check("clr_drop_entry2", rd1_b, 32'h0);
    check("clr_entry0", rd2_b, 32'h00010000);

    // Reset mid-init at CNT=8 restarts the walk.
    apply(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    tick();
    idle(8);
    apply(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0);
    tick();
    idle(15);
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h0);
    check("rst_mid_still_busy", 32'(busy_b), 32'h1);
    tick();
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h0);
    check("rst_mid_done", 32'(busy_b), 32'h0);
    check("rst_mid_entry15", rd2_b, 32'h00014008);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      apply(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            4'($urandom), 4'($urandom), 4'($urandom), $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
